mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/constants_pkg.sv | 16 +
 rtl/mem_req_arbiter_tag_fifo.sv | 74 +++++++
 rtl/mem_req_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/constants_pkg.sv
// ----------------------------------------------------------------------------
// constants_pkg
// Shared widths for the memory request path and the tag type that names a
// requester. tag_t is sized for the largest supported requester count so the
// same type works for any NUM_REQ build.
// ----------------------------------------------------------------------------
package constants_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int MAX_NUM_REQ = 4;
    localparam int TAG_WIDTH   = $clog2(MAX_NUM_REQ);

    typedef logic [TAG_WIDTH-1:0] tag_t;

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo
// Synchronous FIFO that remembers which requester owns each outstanding
// memory request, in issue order.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   enqueue a tag (ignored when full)
//   pop               dequeue the head tag (ignored when empty)
//   pop_data          current head tag
//   full, empty       occupancy flags
//   count             number of stored tags, 0..DEPTH
// ----------------------------------------------------------------------------
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    // A simultaneous push and pop leaves the count untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// mem_req_arbiter
// Shares one in-order memory port among NUM_REQ requesters. A winner is chosen
// round-robin (or fixed priority when MEM_ARB_STRICT_PRIO_EN is defined), its
// request is passed through to memory, and its index is queued in a tag FIFO
// so that each in-order memory response is routed back to its owner one
// cycle later.
//
// Build option:
//   MEM_ARB_STRICT_PRIO_EN  lowest-index requester always wins; no rr pointer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   r_req_vld/rdy/addr       per-requester request channel
//   r_rsp_vld, r_rsp_data    one-hot response valid, shared response data
//   m_req_vld/rdy/addr       memory request channel
//   m_rsp_vld, m_rsp_data    memory response (no backpressure)
//   busy                     requests outstanding or a grant is held
//   err_unexp_rsp            sticky: response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module mem_req_arbiter
    import constants_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            r_req_vld,
    output logic [NUM_REQ-1:0]            r_req_rdy,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_req_addr,
    output logic [NUM_REQ-1:0]            r_rsp_vld,
    output logic [DATA_WIDTH-1:0]         r_rsp_data,
    output logic                          m_req_vld,
    input  logic                          m_req_rdy,
    output logic [ADDR_WIDTH-1:0]         m_req_addr,
    input  logic                          m_rsp_vld,
    input  logic [DATA_WIDTH-1:0]         m_rsp_data,
    output logic                          busy,
    output logic                          err_unexp_rsp
);

    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic                  grant_lock;
    tag_t                  grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
`ifndef MEM_ARB_STRICT_PRIO_EN
    tag_t                  rr_ptr;
`endif

    tag_t                  winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    int                    best_dist;
    int                    cand_dist;
    tag_t                  sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  handshake;
    logic                  rsp_pop;
    logic [NUM_REQ-1:0]    head_onehot;

    tag_t                  fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    // Pick the valid requester closest to the search start: distance from
    // rr_ptr in round-robin mode, plain index under fixed priority.
    always_comb begin
        winner    = '0;
        win_addr  = '0;
        best_dist = NUM_REQ;
        cand_dist = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_req_vld[j]) begin
`ifdef MEM_ARB_STRICT_PRIO_EN
                cand_dist = j;
`else
                cand_dist = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
`endif
                if (cand_dist < best_dist) begin
                    best_dist = cand_dist;
                    winner    = tag_t'(j);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (tag_t'(j) == winner) begin
                win_addr = r_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // A held grant overrides the live arbitration result, even if its
    // requester has since dropped valid. Eligibility uses the registered
    // FIFO state, so a pop this cycle cannot open room for a push.
    assign sel_idx    = grant_lock ? grant_idx  : winner;
    assign sel_addr   = grant_lock ? grant_addr : win_addr;
    assign m_req_vld  = ~rst & (grant_lock | ((|r_req_vld) & ~fifo_full));
    assign m_req_addr = m_req_vld ? sel_addr : '0;
    assign handshake  = m_req_vld & m_req_rdy;
    assign rsp_pop    = m_rsp_vld & ~fifo_empty;
    assign busy       = ~rst & (grant_lock | (fifo_count != '0));

    // Acceptance is passed straight through from memory to the selected owner;
    // the head one-hot steers the next registered response.
    always_comb begin
        r_req_rdy   = '0;
        head_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            r_req_rdy[j]   = handshake && (tag_t'(j) == sel_idx);
            head_onehot[j] = (tag_t'(j) == fifo_head);
        end
    end

    // Grant lock, arbitration pointer, response register and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_lock    <= 1'b0;
            grant_idx     <= '0;
            grant_addr    <= '0;
`ifndef MEM_ARB_STRICT_PRIO_EN
            rr_ptr        <= '0;
`endif
            r_rsp_vld     <= '0;
            r_rsp_data    <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (handshake) begin
                grant_lock <= 1'b0;
`ifndef MEM_ARB_STRICT_PRIO_EN
                rr_ptr     <= (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + tag_t'(1);
`endif
            end else if (m_req_vld && !grant_lock) begin
                grant_lock <= 1'b1;
                grant_idx  <= winner;
                grant_addr <= win_addr;
            end

            r_rsp_vld <= rsp_pop ? head_onehot : '0;
            if (rsp_pop) begin
                r_rsp_data <= m_rsp_data;
            end
            if (m_rsp_vld && fifo_empty) begin
                err_unexp_rsp <= 1'b1;
            end
        end
    end

    tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_WIDTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (handshake),
        .push_data (sel_idx),
        .pop       (rsp_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
